// File: rtl/tpu_sequencer.sv
// Program-driven control sequencer for the systolic-array TPU: fetches from a host-loaded
// instruction memory and drives array strobes. Define TPU_SEQ_LOOP_EN to enable the LOOP opcode.
module tpu_sequencer #(
    parameter int ADDR_W         = 13,
    parameter int IMEM_DEPTH     = 16,
    parameter int COMPUTE_CYCLES = 4,
    localparam int PC_W          = $clog2(IMEM_DEPTH),
    localparam int IW            = ADDR_W + 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              imem_we,
    input  logic [PC_W-1:0]   imem_waddr,
    input  logic [IW-1:0]     imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [PC_W-1:0]   pc,
    output logic [ADDR_W-1:0] base_address,
    output logic              load_weight,
    output logic              load_input,
    output logic              valid,
    output logic              store
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_HALT        = 3'b000,
        OP_LOAD_ADDR   = 3'b001,
        OP_LOAD_WEIGHT = 3'b010,
        OP_LOAD_INPUTS = 3'b011,
        OP_COMPUTE     = 3'b100,
        OP_STORE       = 3'b101,
        OP_WAIT        = 3'b110,
        OP_LOOP        = 3'b111
    } op_t;

    localparam logic [PC_W-1:0] PC_LAST    = PC_W'(IMEM_DEPTH - 1);
    localparam logic [7:0]      CC_DEFAULT = 8'(COMPUTE_CYCLES);

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [IW-1:0]       ir_q;
    logic [IW-1:0]       imem [IMEM_DEPTH];

    op_t                 opcode;
    logic [ADDR_W-1:0]   operand;
    logic [7:0]          op_n;
    logic [7:0]          compute_len;
    logic [7:0]          wait_len;
    logic                exec_last;
    logic                loop_jump;
    logic [PC_W-1:0]     loop_target;

    assign opcode      = op_t'(ir_q[IW-1:ADDR_W]);
    assign operand     = ir_q[ADDR_W-1:0];
    assign op_n        = operand[7:0];
    assign compute_len = (op_n == 8'd0) ? CC_DEFAULT : op_n;
    assign wait_len    = (op_n == 8'd0) ? 8'd1 : op_n;

    // Program memory is not reset; writes only land while the sequencer is not running.
    always_ff @(posedge clk) begin
        if (imem_we && (state_q == S_IDLE || state_q == S_DONE)) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_FETCH) begin
            ir_q <= imem[pc_q];
        end
    end

    always_comb begin
        exec_last = 1'b1;
        if (opcode == OP_COMPUTE) begin
            exec_last = (cnt_q == compute_len - 8'd1);
        end else if (opcode == OP_WAIT) begin
            exec_last = (cnt_q == wait_len - 8'd1);
        end
    end

`ifdef TPU_SEQ_LOOP_EN
    logic       loop_active_q, loop_active_d;
    logic [7:0] loop_rem_q, loop_rem_d;
    logic [7:0] loop_cnt;

    assign loop_cnt    = operand[PC_W+7:PC_W];
    assign loop_target = operand[PC_W-1:0];

    // A single shared loop counter; first LOOP arms it, later ones count it down.
    always_comb begin
        loop_jump     = 1'b0;
        loop_active_d = loop_active_q;
        loop_rem_d    = loop_rem_q;
        if (state_q == S_EXEC && opcode == OP_LOOP) begin
            if (!loop_active_q) begin
                if (loop_cnt != 8'd0) begin
                    loop_active_d = 1'b1;
                    loop_rem_d    = loop_cnt - 8'd1;
                    loop_jump     = 1'b1;
                end
            end else if (loop_rem_q == 8'd0) begin
                loop_active_d = 1'b0;
            end else begin
                loop_rem_d = loop_rem_q - 8'd1;
                loop_jump  = 1'b1;
            end
        end else if (state_q == S_DONE) begin
            loop_active_d = 1'b0;
            loop_rem_d    = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loop_active_q <= 1'b0;
            loop_rem_q    <= 8'd0;
        end else begin
            loop_active_q <= loop_active_d;
            loop_rem_q    <= loop_rem_d;
        end
    end
`else
    assign loop_jump   = 1'b0;
    assign loop_target = '0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (opcode == OP_LOAD_ADDR) begin
                    base_d = operand;
                end
                if (!exec_last) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = 8'd0;
                    if (opcode == OP_HALT) begin
                        state_d = S_DONE;
                    end else if (loop_jump) begin
                        pc_d    = loop_target;
                        state_d = S_FETCH;
                    end else if (pc_q == PC_LAST) begin
                        // Falling off the last slot ends the run instead of wrapping.
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                pc_d    = '0;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= 8'd0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
        end
    end

    // Strobes are purely combinational from state so an asynchronous reset drops them at once.
    always_comb begin
        load_weight = 1'b0;
        load_input  = 1'b0;
        valid       = 1'b0;
        store       = 1'b0;
        if (state_q == S_EXEC) begin
            load_weight = (opcode == OP_LOAD_WEIGHT);
            load_input  = (opcode == OP_LOAD_INPUTS);
            valid       = (opcode == OP_COMPUTE);
            store       = (opcode == OP_STORE);
        end
    end

    assign busy         = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign done         = (state_q == S_DONE);
    assign pc           = pc_q;
    assign base_address = base_q;

endmodule

// File: tb/tb_tpu_sequencer.sv
// Directed self-checking bench for tpu_sequencer (default parameters); honours TPU_SEQ_LOOP_EN.
module tb_tpu_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        imem_we;
    logic [3:0]  imem_waddr;
    logic [15:0] imem_wdata;
    logic        busy;
    logic        done;
    logic [3:0]  pc;
    logic [12:0] base_address;
    logic        load_weight;
    logic        load_input;
    logic        valid;
    logic        store;

    int n_checks;
    int n_fail;

    // Per-run statistics gathered by run_prog
    int n_lw, n_li, n_valid, n_store, valid_runs;
    int first_valid, last_valid, done_cyc, viol, pc_dec, max_pc;

    localparam logic [2:0] HALT = 3'b000, LDA = 3'b001, LDW = 3'b010, LDI = 3'b011;
    localparam logic [2:0] CMP = 3'b100, STO = 3'b101, WAI = 3'b110, LOOP = 3'b111;

    tpu_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .busy         (busy),
        .done         (done),
        .pc           (pc),
        .base_address (base_address),
        .load_weight  (load_weight),
        .load_input   (load_input),
        .valid        (valid),
        .store        (store)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ins(input logic [2:0] op, input logic [12:0] opd);
        return {op, opd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_slot(input int slot, input logic [15:0] word);
        imem_we    = 1'b1;
        imem_waddr = 4'(slot);
        imem_wdata = word;
        tick();
        imem_we    = 1'b0;
    endtask

    // Pulses start, then records strobe activity; cycle 0 is the first FETCH cycle.
    task automatic run_prog(input int max_cyc);
        int s;
        int prev_pc;
        logic prev_valid;
        n_lw = 0; n_li = 0; n_valid = 0; n_store = 0; valid_runs = 0;
        first_valid = -1; last_valid = -1; done_cyc = -1; viol = 0; pc_dec = 0; max_pc = 0;
        prev_pc = 0; prev_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            s = int'(load_weight) + int'(load_input) + int'(valid) + int'(store);
            if (s > 1) viol++;
            if (!busy && s != 0) viol++;
            if (load_weight) n_lw++;
            if (load_input) n_li++;
            if (store) n_store++;
            if (valid) begin
                n_valid++;
                last_valid = c;
                if (first_valid < 0) first_valid = c;
                if (!prev_valid) valid_runs++;
            end
            if (busy && int'(pc) < prev_pc) pc_dec++;
            if (int'(pc) > max_pc) max_pc = int'(pc);
            prev_pc = int'(pc);
            prev_valid = valid;
            if (done) begin
                done_cyc = c;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        start      = 1'bx;
        imem_we    = 1'b0;
        imem_waddr = 'x;
        imem_wdata = 'x;
        tick(); tick();
        n_checks++;
        if ({busy, done, load_weight, load_input, valid, store} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {busy, done, load_weight, load_input, valid, store});
        end
        n_checks++;
        if (pc !== 4'd0) begin
            n_fail++; $display("FAIL reset_pc: got %0d expected 0", pc);
        end
        n_checks++;
        if (base_address !== 13'd0) begin
            n_fail++; $display("FAIL reset_base: got %h expected 000", base_address);
        end
        start = 1'b0;
        reset = 1'b0;
        tick();
        write_slot(0, ins(HALT, 13'd0));
        run_prog(20);
        n_checks++;
        if (done_cyc !== 2) begin
            n_fail++; $display("FAIL halt_only_done_cyc: got %0d expected 2", done_cyc);
        end
        n_checks++;
        if (n_lw + n_li + n_valid + n_store + viol !== 0) begin
            n_fail++; $display("FAIL halt_only_strobes: got %0d expected 0",
                               n_lw + n_li + n_valid + n_store + viol);
        end
        tick();
        n_checks++;
        if ({busy, done, pc} !== 6'b0) begin
            n_fail++; $display("FAIL halt_only_idle: got busy=%b done=%b pc=%0d expected 0 0 0",
                               busy, done, pc);
        end
    endtask

    task automatic test_basic_program();
        write_slot(0, ins(LDA, 13'h0A5));
        write_slot(1, ins(LDW, 13'd0));
        write_slot(2, ins(LDI, 13'd0));
        write_slot(3, ins(CMP, 13'd0));
        write_slot(4, ins(STO, 13'd0));
        write_slot(5, ins(HALT, 13'd0));
        run_prog(100);
        // F/E pairs: LDA c0-1, LDW c2-3, LDI c4-5, CMP c6-10, STO c11-12, HALT c13-14, DONE c15
        n_checks++;
        if (done_cyc !== 15) begin
            n_fail++; $display("FAIL basic_done_cyc: got %0d expected 15", done_cyc);
        end
        n_checks++;
        if (base_address !== 13'h0A5) begin
            n_fail++; $display("FAIL basic_base: got %h expected 0a5", base_address);
        end
        n_checks++;
        if ({n_lw, n_li, n_store} !== {32'd1, 32'd1, 32'd1}) begin
            n_fail++; $display("FAIL basic_strobe_counts: got lw=%0d li=%0d st=%0d expected 1 1 1",
                               n_lw, n_li, n_store);
        end
        n_checks++;
        if ({n_valid, valid_runs, first_valid, last_valid} !== {32'd4, 32'd1, 32'd7, 32'd10}) begin
            n_fail++; $display("FAIL basic_valid: got n=%0d runs=%0d first=%0d last=%0d expected 4 1 7 10",
                               n_valid, valid_runs, first_valid, last_valid);
        end
        n_checks++;
        if (viol !== 0) begin
            n_fail++; $display("FAIL basic_onehot: got %0d expected 0", viol);
        end
        tick();
        n_checks++;
        if ({busy, done, pc} !== 6'b0) begin
            n_fail++; $display("FAIL basic_idle: got busy=%b done=%b pc=%0d expected 0 0 0", busy, done, pc);
        end
    endtask

    task automatic test_compute_wait();
        write_slot(0, ins(CMP, 13'd7));
        write_slot(1, ins(WAI, 13'd3));
        write_slot(2, ins(HALT, 13'd0));
        run_prog(100);
        // CMP F c0, E c1-7; WAIT F c8, E c9-11; HALT F c12, E c13; DONE c14
        n_checks++;
        if (done_cyc !== 14) begin
            n_fail++; $display("FAIL cw_done_cyc: got %0d expected 14", done_cyc);
        end
        n_checks++;
        if ({n_valid, valid_runs, first_valid, last_valid} !== {32'd7, 32'd1, 32'd1, 32'd7}) begin
            n_fail++; $display("FAIL cw_valid: got n=%0d runs=%0d first=%0d last=%0d expected 7 1 1 7",
                               n_valid, valid_runs, first_valid, last_valid);
        end
        n_checks++;
        if (n_lw + n_li + n_store + viol !== 0) begin
            n_fail++; $display("FAIL cw_other_strobes: got %0d expected 0", n_lw + n_li + n_store + viol);
        end
        n_checks++;
        if (base_address !== 13'h0A5) begin
            n_fail++; $display("FAIL cw_base_hold: got %h expected 0a5", base_address);
        end
        tick();
    endtask

    task automatic test_all_store();
        for (int i = 0; i < 16; i++) write_slot(i, ins(STO, 13'd0));
        for (int r = 0; r < 2; r++) begin
            run_prog(200);
            n_checks++;
            if (done_cyc !== 32) begin
                n_fail++; $display("FAIL store_done_cyc run%0d: got %0d expected 32", r, done_cyc);
            end
            n_checks++;
            if (n_store !== 16) begin
                n_fail++; $display("FAIL store_count run%0d: got %0d expected 16", r, n_store);
            end
            n_checks++;
            if ({pc_dec, max_pc, viol} !== {32'd0, 32'd15, 32'd0}) begin
                n_fail++; $display("FAIL store_pc run%0d: got dec=%0d max=%0d viol=%0d expected 0 15 0",
                                   r, pc_dec, max_pc, viol);
            end
            tick();
            n_checks++;
            if ({busy, pc} !== 5'b0) begin
                n_fail++; $display("FAIL store_idle run%0d: got busy=%b pc=%0d expected 0 0", r, busy, pc);
            end
        end
    endtask

    task automatic test_midrun_reset();
        int n_done;
        write_slot(0, ins(CMP, 13'd20));
        write_slot(1, ins(HALT, 13'd0));
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        imem_we    = 1'b1;
        imem_waddr = 4'd1;
        imem_wdata = ins(STO, 13'd0);
        start      = 1'b1;
        tick();
        imem_we = 1'b0;
        start   = 1'b0;
        n_checks++;
        if ({busy, valid, pc} !== {1'b1, 1'b1, 4'd0}) begin
            n_fail++; $display("FAIL mid_ignore_start: got busy=%b valid=%b pc=%0d expected 1 1 0",
                               busy, valid, pc);
        end
        tick(); tick();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, valid, pc} !== 7'b0) begin
            n_fail++; $display("FAIL mid_async_drop: got busy=%b done=%b valid=%b pc=%0d expected 0 0 0 0",
                               busy, done, valid, pc);
        end
        n_checks++;
        if (base_address !== 13'd0) begin
            n_fail++; $display("FAIL mid_reset_base: got %h expected 000", base_address);
        end
        tick();
        reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (done || busy) n_done++;
            tick();
        end
        n_checks++;
        if (n_done !== 0) begin
            n_fail++; $display("FAIL mid_no_done: got %0d active cycles expected 0", n_done);
        end
        run_prog(100);
        n_checks++;
        if ({done_cyc, n_valid, n_store} !== {32'd23, 32'd20, 32'd0}) begin
            n_fail++; $display("FAIL mid_rerun: got done=%0d valid=%0d store=%0d expected 23 20 0",
                               done_cyc, n_valid, n_store);
        end
        tick();
    endtask

    task automatic test_loop();
        int exp_li, exp_valid, exp_runs, exp_done;
`ifdef TPU_SEQ_LOOP_EN
        exp_li = 3; exp_valid = 6; exp_runs = 3; exp_done = 23;
`else
        exp_li = 1; exp_valid = 2; exp_runs = 1; exp_done = 9;
`endif
        write_slot(0, ins(LDI, 13'd0));
        write_slot(1, ins(CMP, 13'd2));
        write_slot(2, ins(LOOP, 13'h020));
        write_slot(3, ins(HALT, 13'd0));
        for (int r = 0; r < 2; r++) begin
            run_prog(200);
            n_checks++;
            if (n_li !== exp_li) begin
                n_fail++; $display("FAIL loop_li run%0d: got %0d expected %0d", r, n_li, exp_li);
            end
            n_checks++;
            if ({n_valid, valid_runs} !== {exp_valid, exp_runs}) begin
                n_fail++; $display("FAIL loop_valid run%0d: got n=%0d runs=%0d expected %0d %0d",
                                   r, n_valid, valid_runs, exp_valid, exp_runs);
            end
            n_checks++;
            if (done_cyc !== exp_done) begin
                n_fail++; $display("FAIL loop_done_cyc run%0d: got %0d expected %0d", r, done_cyc, exp_done);
            end
            n_checks++;
            if (viol !== 0) begin
                n_fail++; $display("FAIL loop_onehot run%0d: got %0d expected 0", r, viol);
            end
            tick();
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        start      = 1'b0;
        imem_we    = 1'b0;
        imem_waddr = '0;
        imem_wdata = '0;
        test_reset();
        test_basic_program();
        test_compute_wait();
        test_all_store();
        test_midrun_reset();
        test_loop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
